// File: rtl/ex_alu_bjp_rslv_pkg.sv
// Shared types and compare opcodes for the branch/jump resolve unit.
package ex_bjp_pkg;

  localparam logic [2:0] BJP_CMP_EQ  = 3'd0;
  localparam logic [2:0] BJP_CMP_NE  = 3'd1;
  localparam logic [2:0] BJP_CMP_LT  = 3'd2;
  localparam logic [2:0] BJP_CMP_GE  = 3'd3;
  localparam logic [2:0] BJP_CMP_LTU = 3'd4;
  localparam logic [2:0] BJP_CMP_GEU = 3'd5;

  typedef struct packed {
    logic bjp;
    logic prdt;
    logic rslv;
    logic mispred;
    logic mret;
    logic dret;
    logic fencei;
  } bjp_pay_t;

endpackage

// File: rtl/ex_alu_bjp_rslv_if.sv
// Request/result bundle of the branch/jump resolve unit.
// E203_BJP_PERF_CNT_EN adds the performance counter signals.
interface ex_alu_bjp_rslv_if #(
  parameter int XLEN    = 32,
  parameter int PC_SIZE = 32,
  parameter int CNT_W   = 16
);
  logic               i_valid;
  logic               i_ready;
  logic [XLEN-1:0]    i_rs1;
  logic [XLEN-1:0]    i_rs2;
  logic [XLEN-1:0]    i_imm;
  logic [PC_SIZE-1:0] i_pc;
  logic [2:0]         i_cmp_op;
  logic               i_bxx;
  logic               i_jump;
  logic               i_rv32;
  logic               i_bprdt;
  logic               i_mret;
  logic               i_dret;
  logic               i_fencei;
  logic               o_valid;
  logic               o_ready;
  logic               o_cmt_bjp;
  logic               o_cmt_prdt;
  logic               o_cmt_rslv;
  logic               o_cmt_mispred;
  logic               o_cmt_mret;
  logic               o_cmt_dret;
  logic               o_cmt_fencei;
  logic [PC_SIZE-1:0] o_cmt_tgt;
  logic [XLEN-1:0]    o_wbck_wdat;
  logic               o_wbck_err;
`ifdef E203_BJP_PERF_CNT_EN
  logic [CNT_W-1:0]   o_cnt_bjp;
  logic [CNT_W-1:0]   o_cnt_mispred;
  logic               i_cnt_clr;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

  modport master (
`ifdef E203_BJP_PERF_CNT_EN
    output i_cnt_clr,
    input  o_cnt_bjp, o_cnt_mispred,
`endif
    output i_valid, i_rs1, i_rs2, i_imm, i_pc,
    output i_cmp_op, i_bxx, i_jump, i_rv32,
    output i_bprdt, i_mret, i_dret, i_fencei,
    output o_ready,
    input  i_ready, o_valid,
    input  o_cmt_bjp, o_cmt_prdt, o_cmt_rslv,
    input  o_cmt_mispred, o_cmt_mret, o_cmt_dret,
    input  o_cmt_fencei, o_cmt_tgt,
    input  o_wbck_wdat, o_wbck_err
  );

  modport slave (
`ifdef E203_BJP_PERF_CNT_EN
    input  i_cnt_clr,
    output o_cnt_bjp, o_cnt_mispred,
`endif
    input  i_valid, i_rs1, i_rs2, i_imm, i_pc,
    input  i_cmp_op, i_bxx, i_jump, i_rv32,
    input  i_bprdt, i_mret, i_dret, i_fencei,
    input  o_ready,
    output i_ready, o_valid,
    output o_cmt_bjp, o_cmt_prdt, o_cmt_rslv,
    output o_cmt_mispred, o_cmt_mret, o_cmt_dret,
    output o_cmt_fencei, o_cmt_tgt,
    output o_wbck_wdat, o_wbck_err
  );

endinterface

// File: rtl/ex_bjp_cmp.sv
// Dedicated branch comparator; reserved opcodes resolve to not-taken.
module ex_bjp_cmp
  import ex_bjp_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [2:0]      op,
  output logic            cmp
);

  logic eq;
  logic lt;
  logic ltu;

  assign eq  = (rs1 == rs2);
  assign lt  = ($signed(rs1) < $signed(rs2));
  assign ltu = (rs1 < rs2);

  always_comb begin
    cmp = 1'b0;
    case (op)
      BJP_CMP_EQ:  cmp = eq;
      BJP_CMP_NE:  cmp = !eq;
      BJP_CMP_LT:  cmp = lt;
      BJP_CMP_GE:  cmp = !lt;
      BJP_CMP_LTU: cmp = ltu;
      BJP_CMP_GEU: cmp = !ltu;
      default:     cmp = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_alu_bjp_rslv.sv
// Branch/jump resolve unit with one registered output stage.
// E203_BJP_PERF_CNT_EN enables saturating bjp/mispredict counters.
module ex_alu_bjp_rslv
  import ex_bjp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PC_SIZE = 32,
  parameter int CNT_W   = 16
) (
  input logic              clk,
  input logic              rst,
  ex_alu_bjp_rslv_if.slave bus
);

  logic               cmp;
  logic               acc;
  bjp_pay_t           pay_d;
  bjp_pay_t           pay_q;
  logic               vld_q;
  logic [PC_SIZE-1:0] link_pc;
  logic [PC_SIZE-1:0] tgt_d;
  logic [PC_SIZE-1:0] tgt_q;
  logic [XLEN-1:0]    wdat_d;
  logic [XLEN-1:0]    wdat_q;

  ex_bjp_cmp #(.XLEN(XLEN)) u_cmp (
    .rs1 (bus.i_rs1),
    .rs2 (bus.i_rs2),
    .op  (bus.i_cmp_op),
    .cmp (cmp)
  );

  assign bus.i_ready = !vld_q | bus.o_ready;
  assign acc = bus.i_valid & bus.i_ready;

  always_comb begin
    pay_d         = '0;
    pay_d.bjp     = bus.i_bxx | bus.i_jump;
    pay_d.prdt    = bus.i_bprdt;
    pay_d.rslv    = bus.i_jump | (bus.i_bxx & cmp);
    pay_d.mispred = pay_d.bjp & (pay_d.rslv ^ bus.i_bprdt);
    pay_d.mret    = bus.i_mret;
    pay_d.dret    = bus.i_dret;
    pay_d.fencei  = bus.i_fencei;
  end

  // Own adders: address wrap at 2^PC_SIZE is silent
  assign link_pc = bus.i_pc
                 + (bus.i_rv32 ? PC_SIZE'(4) : PC_SIZE'(2));
  assign tgt_d   = bus.i_pc + bus.i_imm[PC_SIZE-1:0];
  assign wdat_d  = XLEN'(link_pc);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      pay_q  <= '0;
      tgt_q  <= '0;
      wdat_q <= '0;
    end else if (acc) begin
      vld_q  <= 1'b1;
      pay_q  <= pay_d;
      tgt_q  <= tgt_d;
      wdat_q <= wdat_d;
    end else if (bus.o_ready) begin
      vld_q  <= 1'b0;
    end
  end

  assign bus.o_valid       = vld_q;
  assign bus.o_cmt_bjp     = pay_q.bjp;
  assign bus.o_cmt_prdt    = pay_q.prdt;
  assign bus.o_cmt_rslv    = pay_q.rslv;
  assign bus.o_cmt_mispred = pay_q.mispred;
  assign bus.o_cmt_mret    = pay_q.mret;
  assign bus.o_cmt_dret    = pay_q.dret;
  assign bus.o_cmt_fencei  = pay_q.fencei;
  assign bus.o_cmt_tgt     = tgt_q;
  assign bus.o_wbck_wdat   = wdat_q;
  assign bus.o_wbck_err    = 1'b0;

`ifdef E203_BJP_PERF_CNT_EN
  logic             hs;
  logic [CNT_W-1:0] cnt_bjp;
  logic [CNT_W-1:0] cnt_mis;

  assign hs = vld_q & bus.o_ready;

  // Clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst | bus.i_cnt_clr) begin
      cnt_bjp <= '0;
      cnt_mis <= '0;
    end else if (hs) begin
      if (pay_q.bjp && (cnt_bjp != '1))
        cnt_bjp <= cnt_bjp + CNT_W'(1);
      if (pay_q.mispred && (cnt_mis != '1))
        cnt_mis <= cnt_mis + CNT_W'(1);
    end
  end

  assign bus.o_cnt_bjp     = cnt_bjp;
  assign bus.o_cnt_mispred = cnt_mis;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_ex_alu_bjp_rslv.sv
// Scoreboard bench for ex_alu_bjp_rslv (XLEN = PC_SIZE = 32).
module tb_ex_alu_bjp_rslv;

  typedef struct {
    logic [31:0] rs1, rs2, imm, pc;
    logic [2:0]  op;
    logic        bxx, jump, rv32, bprdt;
    logic        mret, dret, fencei;
  } req_t;

  typedef struct {
    logic        bjp, prdt, rslv, mispred;
    logic        mret, dret, fencei;
    logic [31:0] tgt, wdat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  ex_alu_bjp_rslv_if #(.XLEN(32), .PC_SIZE(32), .CNT_W(2)) bus ();

  ex_alu_bjp_rslv #(.XLEN(32), .PC_SIZE(32), .CNT_W(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input req_t r);
    exp_t e;
    logic c;
    case (r.op)
      3'd0:    c = (r.rs1 == r.rs2);
      3'd1:    c = (r.rs1 != r.rs2);
      3'd2:    c = ($signed(r.rs1) < $signed(r.rs2));
      3'd3:    c = ($signed(r.rs1) >= $signed(r.rs2));
      3'd4:    c = (r.rs1 < r.rs2);
      3'd5:    c = (r.rs1 >= r.rs2);
      default: c = 1'b0;
    endcase
    e.bjp     = r.bxx | r.jump;
    e.prdt    = r.bprdt;
    e.rslv    = r.jump ? 1'b1 : (r.bxx & c);
    e.mispred = e.bjp & (e.rslv != r.bprdt);
    e.mret    = r.mret;
    e.dret    = r.dret;
    e.fencei  = r.fencei;
    e.tgt     = r.pc + r.imm;
    e.wdat    = r.pc + (r.rv32 ? 32'd4 : 32'd2);
    return e;
  endfunction

  function automatic req_t mk(input logic [2:0] op,
                              input logic [31:0] rs1, rs2,
                              input logic [31:0] imm, pc,
                              input logic bxx, jump,
                              input logic rv32, bprdt);
    req_t r;
    r.op = op; r.rs1 = rs1; r.rs2 = rs2;
    r.imm = imm; r.pc = pc;
    r.bxx = bxx; r.jump = jump;
    r.rv32 = rv32; r.bprdt = bprdt;
    r.mret = 1'b0; r.dret = 1'b0; r.fencei = 1'b0;
    return r;
  endfunction

  task automatic apply(input req_t r);
    bus.i_rs1 = r.rs1; bus.i_rs2 = r.rs2;
    bus.i_imm = r.imm; bus.i_pc = r.pc;
    bus.i_cmp_op = r.op;
    bus.i_bxx = r.bxx; bus.i_jump = r.jump;
    bus.i_rv32 = r.rv32; bus.i_bprdt = r.bprdt;
    bus.i_mret = r.mret; bus.i_dret = r.dret;
    bus.i_fencei = r.fencei;
    bus.i_valid = 1'b1;
  endtask

  task automatic issue(input req_t r);
    apply(r);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.i_ready) begin
        q.push_back(model(r));
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        return;
      end
    end
    check("issue_timeout", 32'd0, 32'd1);
    bus.i_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      if (q.size() == 0) return;
      @(posedge clk); #1;
    end
    check("drain_left", q.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.o_valid && bus.o_ready) begin
      n_out++;
      n_assert++;
      assert (q.size() != 0) else begin
        n_fail++;
        $error("FAIL extra_output observed=%0d expected=0", 1);
      end
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("bjp",     32'(bus.o_cmt_bjp),     32'(e.bjp));
        check("prdt",    32'(bus.o_cmt_prdt),    32'(e.prdt));
        check("rslv",    32'(bus.o_cmt_rslv),    32'(e.rslv));
        check("mispred", 32'(bus.o_cmt_mispred), 32'(e.mispred));
        check("mret",    32'(bus.o_cmt_mret),    32'(e.mret));
        check("dret",    32'(bus.o_cmt_dret),    32'(e.dret));
        check("fencei",  32'(bus.o_cmt_fencei),  32'(e.fencei));
        check("tgt",     bus.o_cmt_tgt,          e.tgt);
        check("wdat",    bus.o_wbck_wdat,        e.wdat);
        check("err",     32'(bus.o_wbck_err),    32'd0);
      end
    end
  end

  initial begin
    req_t r;
    req_t a;
    exp_t ea;
    r = mk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply(r);
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
`ifdef E203_BJP_PERF_CNT_EN
    bus.i_cnt_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(bus.o_valid), 32'd0);
    check("rst_iready", 32'(bus.i_ready), 32'd1);
    check("rst_tgt", bus.o_cmt_tgt, 32'd0);
    check("rst_wdat", bus.o_wbck_wdat, 32'd0);
    @(posedge clk); #1;

    // BEQ taken, predicted not-taken
    issue(mk(3'd0, 32'h5, 32'h5, 32'h40, 32'h1000, 1, 0, 1, 0));
    // Signed/unsigned compares on the same operands
    issue(mk(3'd2, 32'hFFFFFFFF, 32'h1, 32'h8, 32'h200, 1, 0, 1, 1));
    issue(mk(3'd4, 32'hFFFFFFFF, 32'h1, 32'h8, 32'h200, 1, 0, 1, 1));
    issue(mk(3'd5, 32'hFFFFFFFF, 32'h1, 32'h8, 32'h200, 1, 0, 1, 0));
    issue(mk(3'd1, 32'h7, 32'h7, 32'hFFFFFFF0, 32'h300, 1, 0, 0, 0));
    issue(mk(3'd3, 32'h80000000, 32'h0, 32'h4, 32'h300, 1, 0, 1, 1));
    // Jumps, including link wrap
    issue(mk(3'd0, 32'h1, 32'h2, 32'h20, 32'h100, 0, 1, 0, 1));
    issue(mk(3'd0, 32'h1, 32'h2, 32'h10, 32'hFFFFFFFE, 0, 1, 1, 0));
    // Reserved opcodes never taken
    issue(mk(3'd6, 32'h3, 32'h3, 32'h4, 32'h400, 1, 0, 1, 1));
    issue(mk(3'd7, 32'h3, 32'h4, 32'h4, 32'h400, 1, 0, 1, 0));
    // Non-branch passthrough
    r = mk(3'd0, 32'h9, 32'h9, 32'h4, 32'h500, 0, 0, 1, 1);
    r.mret = 1'b1;
    issue(r);
    r.mret = 1'b0; r.dret = 1'b1; r.fencei = 1'b1;
    issue(r);
    drain();

    // Backpressure: first result held, second request stalls
    bus.o_ready = 1'b0;
    a = mk(3'd2, 32'h1, 32'h2, 32'h64, 32'h800, 1, 0, 1, 0);
    ea = model(a);
    issue(a);
    r = mk(3'd0, 32'h1, 32'h2, 32'h10, 32'h900, 0, 1, 0, 0);
    apply(r);
    repeat (3) begin
      @(negedge clk);
      check("bp_iready", 32'(bus.i_ready), 32'd0);
      check("bp_valid", 32'(bus.o_valid), 32'd1);
      check("bp_tgt", bus.o_cmt_tgt, ea.tgt);
      check("bp_wdat", bus.o_wbck_wdat, ea.wdat);
      check("bp_rslv", 32'(bus.o_cmt_rslv), 32'(ea.rslv));
    end
    @(posedge clk); #1;
    bus.o_ready = 1'b1;
    issue(r);
    drain();
    check("out_count", n_out, 32'd14);

    // Reset drops an in-flight result
    bus.o_ready = 1'b0;
    issue(mk(3'd0, 32'h5, 32'h5, 32'h40, 32'h1000, 1, 0, 1, 0));
    @(negedge clk);
    check("pre_rst_valid", 32'(bus.o_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    check("rst2_valid", 32'(bus.o_valid), 32'd0);
    check("rst2_iready", 32'(bus.i_ready), 32'd1);
    check("rst2_rslv", 32'(bus.o_cmt_rslv), 32'd0);
    check("rst2_mispred", 32'(bus.o_cmt_mispred), 32'd0);
    check("rst2_bjp", 32'(bus.o_cmt_bjp), 32'd0);
    check("rst2_tgt", bus.o_cmt_tgt, 32'd0);
    check("rst2_wdat", bus.o_wbck_wdat, 32'd0);
    @(posedge clk); #1;
    bus.o_ready = 1'b1;

`ifdef E203_BJP_PERF_CNT_EN
    bus.i_cnt_clr = 1'b1;
    @(posedge clk); #1;
    bus.i_cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++)
      issue(mk(3'd0, 32'h5, 32'h5, 32'h4, 32'h40, 1, 0, 1, 0));
    drain();
    @(posedge clk); #1;
    check("cnt_bjp_sat", 32'(bus.o_cnt_bjp), 32'd3);
    check("cnt_mis_sat", 32'(bus.o_cnt_mispred), 32'd3);
    bus.i_cnt_clr = 1'b1;
    issue(mk(3'd0, 32'h5, 32'h5, 32'h4, 32'h40, 1, 0, 1, 0));
    drain();
    @(posedge clk); #1;
    bus.i_cnt_clr = 1'b0;
    check("cnt_bjp_clr", 32'(bus.o_cnt_bjp), 32'd0);
    check("cnt_mis_clr", 32'(bus.o_cnt_mispred), 32'd0);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_alu_bjp_rslv.md
Name: ex_alu_bjp_rslv

Overview:
- Parametrised, pipelined successor of the EXU branch/jump resolve unit.
- Resolves conditional branches and unconditional jumps with its own comparator and adders. It does not borrow the shared ALU datapath.
- Registers the result in one output stage with a valid/ready handshake toward commit and writeback.
- Produces link address, branch target and mispredict flag. Optional saturating performance counters are included.

Parameters:
- XLEN, 32, operand/data width.
- PC_SIZE, 32, PC width (PC_SIZE <= XLEN).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  request valid.
- i_ready  out  1  request accepted when i_valid & i_ready.
- i_rs1  in  XLEN  compare operand 1.
- i_rs2  in  XLEN  compare operand 2.
- i_imm  in  XLEN  branch offset, sign-extended.
- i_pc  in  PC_SIZE  instruction PC.
- i_cmp_op  in  3  compare opcode (package encoding).
- i_bxx  in  1  conditional branch.
- i_jump  in  1  unconditional jump (jal/jalr).
- i_rv32  in  1  1 = 32-bit instruction, 0 = 16-bit.
- i_bprdt  in  1  predicted taken.
- i_mret  in  1  mret.
- i_dret  in  1  dret.
- i_fencei  in  1  fence.i.
- o_valid  out  1  result valid.
- o_ready  in  1  downstream accepts result.
- o_cmt_bjp  out  1  instruction is a branch or jump.
- o_cmt_prdt  out  1  registered prediction.
- o_cmt_rslv  out  1  actual taken.
- o_cmt_mispred  out  1  prediction ≠ actual, valid only for branch/jump.
- o_cmt_mret  out  1  registered mret.
- o_cmt_dret  out  1  registered dret.
- o_cmt_fencei  out  1  registered fence.i.
- o_cmt_tgt  out  PC_SIZE  i_pc + i_imm, truncated.
- o_wbck_wdat  out  XLEN  link address pc + 4 or pc + 2, zero-extended.
- o_wbck_err  out  1  constant 0.

Behaviour:
- Pipeline: exactly one output register stage. Latency is 1 cycle from acceptance to o_valid.
- i_ready = !o_valid | o_ready, so back-to-back issue is possible at full throughput.
- Output register loads on i_valid & i_ready.
- o_valid next state:
  - set when a request is accepted;
  - else cleared on o_ready;
  - else held.
- All o_cmt_* outputs, o_cmt_tgt and o_wbck_wdat are stable while o_valid & !o_ready.
- Compare (i_cmp_op):
  - EQ: rs1 == rs2.
  - NE: rs1 != rs2.
  - LT: signed <.
  - GE: signed >=.
  - LTU: unsigned <.
  - GEU: unsigned >=.
  - Reserved opcodes 6 and 7 give cmp = 0.
- Resolve: rslv = i_jump ? 1 : (i_bxx & cmp).
- bjp = i_bxx | i_jump.
- mispred = bjp & (rslv ^ i_bprdt).
- Adders:
  - link = pc + (i_rv32 ? 4 : 2), modulo 2^PC_SIZE, then zero-extended to XLEN.
  - tgt = pc + imm[PC_SIZE-1:0], modulo 2^PC_SIZE. Wrap-around at the top of the address space is silent.
- Non-branch requests (mret/dret/fencei only) pass through with rslv = 0 and mispred = 0.
- Reset (rst = 1 at a clock edge): every output register clears to 0, including o_valid. An in-flight result is dropped. i_ready = 1 in the first cycle after reset.

Optional Feature:
- Macro: E203_BJP_PERF_CNT_EN.
- When defined, adds ports:
  - o_cnt_bjp  out  CNT_W;
  - o_cnt_mispred  out  CNT_W;
  - i_cnt_clr  in  1.
- o_cnt_bjp increments on each output handshake (o_valid & o_ready) with o_cmt_bjp = 1.
- o_cnt_mispred increments on each such handshake with o_cmt_mispred = 1.
- Both counters saturate at all-ones.
- i_cnt_clr (or rst) zeroes both counters and takes priority over a same-cycle increment.
- When undefined, the ports and counter logic are absent.

Decomposition:
- Package ex_bjp_pkg holds:
  - compare opcode constants: BJP_CMP_EQ = 0, NE = 1, LT = 2, GE = 3, LTU = 4, GEU = 5;
  - a struct typedef for the registered output payload.
- One natural sub-module: ex_bjp_cmp, a combinational comparator parametrised by XLEN.

Test Plan:
- XLEN = 32: BEQ with rs1 = rs2 = 0x5, bprdt = 0, o_ready = 1 → next cycle o_valid = 1, rslv = 1, mispred = 1.
- BLT with rs1 = 0xFFFFFFFF, rs2 = 1 → rslv = 1. BLTU with the same operands → rslv = 0. BGEU with the same operands → rslv = 1.
- JAL with pc = 0x100, rv32 = 0, imm = 0x20, bprdt = 1 → wdat = 0x102, tgt = 0x120, rslv = 1, mispred = 0. pc = 0xFFFFFFFE, rv32 = 1 → wdat = 0x2.
- Backpressure: hold o_ready = 0 for 3 cycles with i_valid high → i_ready = 0 and outputs stable. Release → two results in consecutive cycles, no loss or duplication.
- Assert rst while o_valid = 1 → next cycle all outputs 0 and i_ready = 1.
- PERF_CNT_EN with CNT_W = 2: 5 mispredicted branches → both counters saturate at 3. i_cnt_clr asserted in the same cycle as a handshake → counters read 0.
